zxaudio_src_arbiter: RTL

ZXAUDIO_SRC_ARBITER -- requirements
Module: zxaudio_src_arbiter

---
 rtl/zxaudio_pkg.sv | 18 +
 rtl/zxaudio_rr_arbiter.sv | 32 +++
 rtl/zxaudio_src_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/zxaudio_pkg.sv
// zxaudio_pkg: shared definitions for the zxaudio source arbiter slice.
// Holds the arbiter FSM state encoding and the default sample width.
// Build option: ZXAUDIO_SIGNED_OUT_EN (used by zxaudio_src_arbiter) selects
// offset-binary to two's-complement conversion of the delivered sample.
package zxaudio_pkg;

    // Default audio sample width in bits.
    localparam int AUDIO_DW_DEFAULT = 16;

    // Arbiter FSM encoding; the values are visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CONV  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/zxaudio_rr_arbiter.sv
// zxaudio_rr_arbiter: purely combinational round-robin winner selection.
// The search starts at (last_grant + 1) mod NUM_SRC and wraps past
// NUM_SRC-1 back to 0. A source is never passed over more than NUM_SRC-1
// times in a row while it keeps requesting.
module zxaudio_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down to 1 so the nearest requester
    // after last_grant is the one that ends up stored in winner.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_SRC);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zxaudio_src_arbiter.sv
// zxaudio_src_arbiter: picks one of NUM_SRC audio sources round-robin,
// captures its sample, optionally converts it and holds it for the sink.
// Build option: define ZXAUDIO_SIGNED_OUT_EN to invert the sample MSB
// (offset-binary to two's complement); default build passes it unchanged.
// Timing is identical in both builds.
//
// Handshakes: a source sample moves when src_ready[i] is high (one cycle,
// only in GRANT, one-hot); src_valid is only looked at in IDLE. The output
// sample moves on a cycle where out_valid && out_ready are both high;
// out_data/out_src are held stable from out_valid rising until that cycle.
module zxaudio_src_arbiter
    import zxaudio_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int NUM_SRC  = 4,
    parameter int IW       = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*AUDIO_DW-1:0] src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        out_valid,
    output logic [AUDIO_DW-1:0]         out_data,
    output logic [IW-1:0]               out_src,
    input  logic                        out_ready,
    output logic                        busy,
    output state_t                      dbg_state
);

    state_t              state;
    logic [IW-1:0]       winner_q;
    logic [IW-1:0]       last_grant_q;
    logic [AUDIO_DW-1:0] sample_q;

    logic [IW-1:0]       arb_winner;
    logic                arb_any;
    logic [AUDIO_DW-1:0] sel_data;
    logic [AUDIO_DW-1:0] conv_data;

    zxaudio_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_rr (
        .req        (src_valid),
        .last_grant (last_grant_q),
        .winner     (arb_winner),
        .any_req    (arb_any)
    );

    // Mux out the granted source's sample from the packed input bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner_q == IW'(i)) begin
                sel_data = src_data[i*AUDIO_DW +: AUDIO_DW];
            end
        end
    end

`ifdef ZXAUDIO_SIGNED_OUT_EN
    // Offset-binary to two's complement: flip the sign bit only.
    assign conv_data = {~sample_q[AUDIO_DW-1], sample_q[AUDIO_DW-2:0]};
`else
    // Sample delivered exactly as captured.
    assign conv_data = sample_q;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Main FSM: IDLE arbitrates, GRANT strobes src_ready and captures,
    // CONV produces the output sample, HOLD waits for the sink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src_ready    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= '0;
            winner_q     <= '0;
            sample_q     <= '0;
            last_grant_q <= IW'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    src_ready <= '0;
                    out_valid <= 1'b0;
                    if (arb_any) begin
                        winner_q  <= arb_winner;
                        src_ready <= NUM_SRC'(1) << arb_winner;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Capture now; src_valid may drop afterwards without effect.
                    sample_q  <= sel_data;
                    src_ready <= '0;
                    state     <= CONV;
                end
                CONV: begin
                    out_data     <= conv_data;
                    out_src      <= winner_q;
                    last_grant_q <= winner_q;
                    out_valid    <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    src_ready <= '0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
